// File: rtl/mat_pkg.sv
// Shared dimensions and types for the 16x49 * 49x32 matrix multiplier and its
// result requantizer.
package mat_pkg;
  localparam int ROWS_A = 16;
  localparam int COLS_A = 49;
  localparam int COLS_B = 32;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int DEPTH  = ROWS_A * COLS_B;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [OUT_W-1:0] q;
  } wr_t;
endpackage

// File: rtl/mat_result_requant_if.sv
// C-result write strobes in, requantized valid/ready stream out.
interface mat_result_requant_if;
  import mat_pkg::*;
  logic             in_we;
  logic [AW-1:0]    in_addr;
  logic [ACC_W-1:0] in_data;
  logic             in_done;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (output in_we, in_addr, in_data, in_done, out_ready,
                  input  out_valid, out_data, out_last);
  modport slave  (input  in_we, in_addr, in_data, in_done, out_ready,
                  output out_valid, out_data, out_last);
endinterface

// File: rtl/requant_unit.sv
// Combinational requantizer: half-up round, arithmetic shift, optional ReLU,
// saturate to OUT_W signed.
module requant_unit
  import mat_pkg::*;
(
  input  logic signed [ACC_W-1:0] d,
  input  logic        [4:0]       shift,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] q,
  output logic                    sat
);
  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = -Q_MAX - (ACC_W+1)'(1);

  logic signed [ACC_W:0] ext, half, r;

  always_comb begin
    // One extra bit keeps the rounding add from wrapping near +2^31.
    ext  = {d[ACC_W-1], d};
    half = '0;
    if (shift != 5'd0) half[shift - 5'd1] = 1'b1;
    r = (ext + half) >>> shift;
    if (relu_en && r < 0) r = '0;
    sat = 1'b0;
    q   = r[OUT_W-1:0];
    if (r > Q_MAX) begin
      q   = Q_MAX[OUT_W-1:0];
      sat = 1'b1;
    end else if (r < Q_MIN) begin
      q   = Q_MIN[OUT_W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/mat_result_requant.sv
// Collects requantized C results into a 16x32 frame buffer, then drains the
// frame row-major over a valid/ready stream after the multiplier's done pulse.
module mat_result_requant
  import mat_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  mat_result_requant_if.slave  bus,
  input  logic [4:0]           shift_amt,
  input  logic                 relu_en,
  output logic                 busy,
  output logic                 frame_done,
  output logic [AW:0]          sat_cnt,
  output logic                 drop_err
);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SAT_MAX   = '1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  state_t               state;
  wr_t                  pipe;
  logic                 pipe_vld;
  logic [AW-1:0]        rd_addr;
  logic                 first_we;
  logic [OUT_W-1:0]     mem [DEPTH];
  logic signed [OUT_W-1:0] rq;
  logic                 rq_sat;
  logic                 in_range, capture, hshake, rd_en;
  logic [AW-1:0]        rd_idx;

  requant_unit u_rq (
    .d       (bus.in_data),
    .shift   (shift_amt),
    .relu_en (relu_en),
    .q       (rq),
    .sat     (rq_sat)
  );

  assign in_range = {1'b0, bus.in_addr} < DEPTH_W;
  assign capture  = (state == ST_COLLECT) && bus.in_we && in_range;
  assign hshake   = bus.out_valid && bus.out_ready;
  // Element 0 is fetched on leaving FLUSH; later fetches ride each handshake.
  assign rd_en    = ((state == ST_FLUSH) && !pipe_vld) ||
                    ((state == ST_DRAIN) && hshake && !bus.out_last);
  assign rd_idx   = (state == ST_FLUSH) ? '0 : rd_addr;
  assign busy     = (state == ST_DRAIN);

  always_ff @(posedge clk)
    if (pipe_vld) mem[pipe.addr] <= pipe.q;

  always_ff @(posedge clk or posedge reset)
    if (reset)      bus.out_data <= '0;
    else if (rd_en) bus.out_data <= mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_COLLECT;
      pipe          <= '0;
      pipe_vld      <= 1'b0;
      rd_addr       <= '0;
      first_we      <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      frame_done    <= 1'b0;
      sat_cnt       <= '0;
      drop_err      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pipe_vld   <= capture;
      if (capture) pipe <= '{addr: bus.in_addr, q: rq};
      case (state)
        ST_COLLECT: begin
          if (bus.in_we) begin
            first_we <= 1'b0;
            if (first_we) begin
              drop_err <= !in_range;
              sat_cnt  <= (AW+1)'(rq_sat && in_range);
            end else begin
              if (!in_range) drop_err <= 1'b1;
              if (rq_sat && in_range && sat_cnt != SAT_MAX) sat_cnt <= sat_cnt + 1'b1;
            end
          end
          if (bus.in_done) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (bus.in_we || bus.in_done) drop_err <= 1'b1;
          if (!pipe_vld) begin
            state         <= ST_DRAIN;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
            rd_addr       <= AW'(1);
          end
        end
        ST_DRAIN: begin
          if (bus.in_we || bus.in_done) drop_err <= 1'b1;
          if (hshake) begin
            if (bus.out_last) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              frame_done    <= 1'b1;
              first_we      <= 1'b1;
              state         <= ST_COLLECT;
            end else begin
              bus.out_last <= (rd_addr == LAST_ADDR);
              rd_addr      <= rd_addr + 1'b1;
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_result_requant.sv
// Randomized bench for mat_result_requant with an arithmetic reference model
// of the frame buffer and a per-cycle stream compare process.
module tb_mat_result_requant;
  import mat_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  shift_amt;
  logic        relu_en;
  logic        busy, frame_done, drop_err;
  logic [AW:0] sat_cnt;

  mat_result_requant_if bus();

  mat_result_requant dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .shift_amt  (shift_amt),
    .relu_en    (relu_en),
    .busy       (busy),
    .frame_done (frame_done),
    .sat_cnt    (sat_cnt),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_mem   [DEPTH];
  logic [15:0] got       [DEPTH];
  int          sat_model = 0;
  bit          new_frame = 1'b1;
  int          idx = 0;
  bit          chk_en = 1'b0, fd_expect = 1'b0, drain_done = 1'b0, bp_mode = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference requant: floor((d + 2^(sh-1)) / 2^sh), ReLU, clamp to int16.
  function automatic logic [15:0] ref_q(longint d, int sh, bit relu, output bit sat);
    longint r, num, den;
    if (sh == 0) r = d;
    else begin
      den = longint'(1) << sh;
      num = d + den / 2;
      r   = num / den;
      if (num < 0 && (num % den) != 0) r = r - 1;
    end
    if (relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 32767)       begin r = 32767;  sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return 16'(r);
  endfunction

  task automatic wr(int a, int d, bit accept, bit with_done = 1'b0);
    bit s;
    logic [15:0] q;
    bus.in_we   = 1'b1;
    bus.in_addr = a[AW-1:0];
    bus.in_data = d;
    bus.in_done = with_done;
    if (accept) begin
      q = ref_q(longint'(d), int'(shift_amt), relu_en, s);
      if (new_frame) begin sat_model = 0; new_frame = 1'b0; end
      model_mem[a] = q;
      if (s && sat_model < 1023) sat_model++;
    end
    @(posedge clk); #1;
    bus.in_we   = 1'b0;
    bus.in_done = 1'b0;
  endtask

  task automatic done_only();
    bus.in_done = 1'b1;
    @(posedge clk); #1;
    bus.in_done = 1'b0;
  endtask

  task automatic start_chk();
    exp_mem    = model_mem;
    idx        = 0;
    fd_expect  = 1'b0;
    drain_done = 1'b0;
    chk_en     = 1'b1;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 6000 && !drain_done; c++) @(posedge clk);
    #1;
    chk("drain_complete", drain_done, 1);
    new_frame = 1'b1;
  endtask

  task automatic rand_wr(int lo);
    shift_amt = 5'($urandom_range(0, 31));
    relu_en   = 1'($urandom_range(0, 1));
    wr($urandom_range(lo, DEPTH-1), int'($urandom), 1'b1);
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Stream compare: every cycle of a drain, against the snapshot of the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (fd_expect) begin
          chk("frame_done_pulse", frame_done, 1);
          chk("valid_after_last", bus.out_valid, 0);
          fd_expect  = 1'b0;
          drain_done = 1'b1;
          chk_en     = 1'b0;
        end else begin
          chk("frame_done_idle", frame_done, 0);
          if (bus.out_valid) begin
            chk("out_data", bus.out_data, exp_mem[idx]);
            chk("out_last", bus.out_last, idx == DEPTH-1);
            if (bus.out_ready) begin
              got[idx] = bus.out_data;
              if (idx == DEPTH-1) fd_expect = 1'b1;
              idx++;
            end
          end
        end
      end
    end
  end

  initial begin
    bit s;
    reset = 1'b1;
    bus.in_we = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.in_done = 1'b0;
    shift_amt = 5'd0; relu_en = 1'b0;

    chk("model_round_pos", ref_q(383, 8, 1'b0, s), 16'd1);
    chk("model_round_neg", ref_q(-385, 8, 1'b0, s), 16'hFFFE);
    chk("model_sat_pos",   ref_q(64'sh7FFFFFFF, 0, 1'b0, s), 16'h7FFF);
    chk("model_relu",      ref_q(-1000, 2, 1'b1, s), 16'd0);
    chk("model_sat_neg",   ref_q(-64'sh80000000, 0, 1'b0, s), 16'h8000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_drop_err", drop_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Ramp frame, ready held high.
    shift_amt = 5'd8;
    for (int i = 0; i < DEPTH; i++) wr(i, i << 8, 1'b1);
    done_only();
    start_chk();
    @(negedge clk);
    chk("flush_no_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("valid_latency", bus.out_valid, 1);
    chk("busy_drain", busy, 1);
    wait_drain();
    chk("ramp_sat_cnt", sat_cnt, 0);
    chk("ramp_first", got[0], 16'd0);
    chk("ramp_mid", got[300], 16'd300);
    chk("ramp_last", got[511], 16'd511);

    // Directed rounding / ReLU / saturation, random fill, write with done, backpressure.
    bp_mode = 1'b1;
    shift_amt = 5'd8; relu_en = 1'b0;
    wr(0, 383, 1'b1);
    wr(1, -385, 1'b1);
    shift_amt = 5'd0;
    wr(2, 32'h7FFFFFFF, 1'b1);
    shift_amt = 5'd2; relu_en = 1'b1;
    wr(3, -1000, 1'b1);
    shift_amt = 5'd0; relu_en = 1'b0;
    wr(4, int'(32'h80000000), 1'b1);
    @(negedge clk);
    chk("dir_sat_cnt", sat_cnt, 2);
    chk("dir_drop_clear", drop_err, 0);
    @(posedge clk); #1;
    repeat (150) rand_wr(6);
    shift_amt = 5'd4; relu_en = 1'b0;
    wr(5, 32'h50, 1'b1, 1'b1);
    start_chk();
    @(negedge clk);
    chk("f2_sat_cnt", sat_cnt, sat_model);
    repeat (20) @(posedge clk);
    #1;
    wr(0, 12345, 1'b0);
    done_only();
    @(negedge clk);
    chk("drop_err_drain", drop_err, 1);
    wait_drain();
    chk("drop_err_sticky", drop_err, 1);
    chk("got_383", got[0], 16'd1);
    chk("got_m385", got[1], 16'hFFFE);
    chk("got_satpos", got[2], 16'h7FFF);
    chk("got_relu", got[3], 16'd0);
    chk("got_satneg", got[4], 16'h8000);
    chk("got_we_with_done", got[5], 16'd5);

    // Next frame clears sticky flags; reset during drain.
    bp_mode = 1'b0;
    shift_amt = 5'd3; relu_en = 1'b0;
    wr(7, 1000, 1'b1);
    @(negedge clk);
    chk("f3_drop_clear", drop_err, 0);
    chk("f3_sat_clear", sat_cnt, 0);
    @(posedge clk); #1;
    repeat (40) rand_wr(0);
    done_only();
    start_chk();
    for (int c = 0; c < 2000 && idx < 100; c++) begin @(posedge clk); #1; end
    chk("reached_elem_100", idx >= 100, 1);
    chk_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_last", bus.out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_sat_cnt", sat_cnt, 0);
    chk("mid_rst_drop_err", drop_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    new_frame = 1'b1;
    sat_model = 0;

    // Full random frame after reset, random backpressure.
    bp_mode   = 1'b1;
    shift_amt = 5'($urandom_range(0, 20));
    relu_en   = 1'($urandom_range(0, 1));
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom), 1'b1);
    done_only();
    start_chk();
    wait_drain();
    chk("f4_sat_cnt", sat_cnt, sat_model);
    chk("f4_busy_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
